jzjpcc_fetch: RTL
=================

# jzjpcc_fetch

Fetch stage of the jzjpcc pipelined RV32I core. It issues word reads to the instruction memory through a single-outstanding request/acknowledge interface and drives the fetch→decode pipeline register (`instruction_decode`, `currentPC_decode`). It applies control-transfer redirects from decode and stall/flush commands from hazard control. Whenever no valid instruction is available it inserts the nop `addi x0, x0, 0`.

## Interface
- `PC_MAX_B`, default 15: MSB of the word-aligned PC. PCs are carried as `[PC_MAX_B:2]`.
- `RESET_PC`, default 0: word address `[PC_MAX_B:2]` fetched first after reset.

Ports:
- `clock`  in  1  system clock, all state on rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `imem_req`  out  1  read request.
- `imem_addr`  out  `[PC_MAX_B:2]`  read word address; stable while `imem_req` is high and not acked.
- `imem_ack`  in  1  request accepted; `imem_data` is valid in this cycle. Ack may occur in the same cycle as the request.
- `imem_data`  in  `[31:2]`  instruction bits 31:2. Bits 1:0 are implicitly 2'b11.
- `instruction_decode`  out  `[31:2]`  instruction in decode.
- `currentPC_decode`  out  `[PC_MAX_B:2]`  PC of that instruction.
- `pcCTWriteEnable`  in  1  redirect fetch to `controlTransferNewPC`.
- `controlTransferNewPC`  in  `[PC_MAX_B:2]`  redirect target.
- `stall_decode`  in  1  hold the decode register.
- `flush_decode`  in  1  replace the decode register contents with nop.

## Operation
- **NOP:** `instruction_decode` = 30'h0000_0004, which is `0x00000013 >> 2`.
- **Internal state:**
  - `reqPC`: address of the current or next request.
  - `redirPC`: pending redirect target.
  - one-entry buffer `{bufInst, bufPC}`.
  - FSM with states FETCH, HOLD and DISCARD.
- **Output decoding:**
  - `imem_req` = (state != HOLD).
  - `imem_addr` = `reqPC`.
  - Both depend only on registered state; there is no combinational path from inputs to `imem_*`.
- **Decode register update priority:**
  1. `flush_decode` loads NOP.
  2. Otherwise `stall_decode` holds the register.
  3. Otherwise it loads the delivered instruction, if one exists.
  4. Otherwise it loads NOP.
- When NOP is loaded, `currentPC_decode` holds its previous value.
- **FETCH state:**
  - ack, no redirect, decode accepting (no stall, no flush): load `{imem_data, reqPC}`; `reqPC` ← `reqPC`+1; stay in FETCH.
  - ack, no redirect, decode not accepting (stall or flush): capture into the buffer; `reqPC` ← `reqPC`+1; go to HOLD.
  - ack with redirect: drop the data; `reqPC` ← `controlTransferNewPC`; stay in FETCH.
  - no ack, redirect: `redirPC` ← `controlTransferNewPC`; go to DISCARD. The address stays held.
  - no ack, no redirect: stay in FETCH; decode gets NOP unless stalled.
- **HOLD state:**
  - redirect: drop the buffer; `reqPC` ← target; go to FETCH.
  - else, decode accepting: load the buffer into decode; go to FETCH.
  - else: stay in HOLD.
- **DISCARD state:**
  - `imem_req` stays high with the old address. A redirect in this state overwrites `redirPC`.
  - on ack: drop the data; `reqPC` ← `redirPC`, or ← `controlTransferNewPC` if a redirect occurs in the same cycle; go to FETCH.
  - decode never receives an instruction from this state.
- **Arithmetic:** `reqPC`+1 is modulo 2^(PC_MAX_B−1). Wrap from all-ones to 0 is silent.

## Timing
- **Reset values:**
  - state FETCH.
  - `reqPC` = `RESET_PC`, `redirPC` = `RESET_PC`.
  - `instruction_decode` = NOP, `currentPC_decode` = `RESET_PC`.
  - `imem_req` = 1 and `imem_addr` = `RESET_PC` while reset is asserted and after release.
  - buffer cleared to NOP/`RESET_PC`.
- **Assertion mid-operation:** reset asserted during DISCARD or HOLD aborts immediately. The outstanding request is abandoned, and the memory must tolerate this.
- **Latency:**
  - ack in cycle N → instruction visible in decode in cycle N+1.
  - zero-wait ack sustains 1 instruction per cycle.
- **Redirect penalty:**
  - redirect in an ack cycle N → request to the target in N+1.
  - redirect without ack → target requested the cycle after the old request's ack.
- **Simultaneous inputs:**
  - redirect beats stall for the fetch side.
  - flush beats stall for the decode register.
  - flush without redirect does not lose the fetched instruction; it is buffered.

## Configuration
- `JZJPCC_FETCH_PERF_COUNTERS_EN`, when defined, adds two outputs, both reset to 0 and wrapping modulo 2^32:
  - `fetchedCount_fetch` (out, 32): increments each cycle a real instruction is loaded into decode.
  - `bubbleCount_fetch` (out, 32): increments each cycle NOP is loaded while not stalled.
- When undefined, neither port nor counter exists and behaviour is otherwise identical.

## Test plan
- **Reset and streaming:** release reset with ack tied high → decode shows PCs 0,1,2,3 on consecutive cycles with matching `imem_data`. The first cycle after release shows NOP/`RESET_PC`.
- **Wait states:** ack asserted every 3rd cycle → a NOP between instructions, `imem_addr` stable while unacked, no instruction skipped.
- **Stall during ack:** stall for 2 cycles while ack arrives for PC 5 → state HOLD and `imem_req`=0. PC 5's instruction appears in decode the cycle after stall drops, then PC 6 is requested.
- **Redirect with ack pending:** redirect to 0x40 while PC 7 is unacked → `imem_addr` held at 7 until ack, PC 7's data dropped, next request 0x40. A second redirect to 0x80 during DISCARD → 0x80 is requested instead.
- **Wrap-around:** `RESET_PC` = all-ones → next request is 0 with no stall.
- **Counters (macro on) and async reset:** 10 instructions plus 3 bubbles → counts 10/3. Async reset mid-DISCARD → all outputs reset immediately.

Source files
------------

// File: rtl/jzjpcc_fetch_if.sv
// jzjpcc_fetch_if: instruction-memory read channel of the jzjpcc fetch stage.
// The fetch stage can have at most one read outstanding on this channel.
//   req   fetch -> mem  read request
//   addr  fetch -> mem  word address [PC_MAX_B:2]; held stable until acked
//   ack   mem -> fetch  request accepted; data is valid in the same cycle
//   data  mem -> fetch  instruction bits 31:2 (bits 1:0 are always 2'b11)
// Modports: master = fetch stage, slave = instruction memory.
interface jzjpcc_fetch_if #(
  parameter int PC_MAX_B = 15
);
  logic              req;
  logic [PC_MAX_B:2] addr;
  logic              ack;
  logic [31:2]       data;

  modport master (output req, output addr, input ack, input data);
  modport slave  (input req, input addr, output ack, output data);
endinterface

// File: rtl/jzjpcc_fetch.sv
// jzjpcc_fetch: fetch stage of the jzjpcc pipelined RV32I core.
// Issues single-outstanding word reads, feeds the fetch->decode register and
// applies redirects (decode) and stall/flush (hazard control). A nop
// (addi x0,x0,0) is inserted whenever no valid instruction is available.
// Ports:
//   clock, reset            clock; asynchronous active-high reset
//   imem                    instruction-memory channel (master side)
//   instruction_decode      instruction bits 31:2 in decode
//   currentPC_decode        PC of that instruction
//   pcCTWriteEnable         redirect fetch to controlTransferNewPC
//   controlTransferNewPC    redirect target
//   stall_decode            hold the decode register
//   flush_decode            load nop into the decode register
// Optional feature macro JZJPCC_FETCH_PERF_COUNTERS_EN adds
//   fetchedCount_fetch, bubbleCount_fetch (32-bit wrapping event counters).
module jzjpcc_fetch #(
  parameter int                PC_MAX_B = 15,
  parameter logic [PC_MAX_B:2] RESET_PC = {(PC_MAX_B - 1){1'b0}}
) (
  input  logic                clock,
  input  logic                reset,
  jzjpcc_fetch_if.master      imem,
  output logic [31:2]         instruction_decode,
  output logic [PC_MAX_B:2]   currentPC_decode,
  input  logic                pcCTWriteEnable,
  input  logic [PC_MAX_B:2]   controlTransferNewPC,
  input  logic                stall_decode,
  input  logic                flush_decode
`ifdef JZJPCC_FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]         fetchedCount_fetch,
  output logic [31:0]         bubbleCount_fetch
`endif
);

  localparam logic [31:2]       NOP    = 30'h0000_0004;
  localparam logic [PC_MAX_B:2] PC_ONE = {{(PC_MAX_B - 2){1'b0}}, 1'b1};

  // FETCH: requesting normally; HOLD: fetched word parked in the buffer,
  // no request; DISCARD: old request still in flight, its data is dropped.
  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [PC_MAX_B:2] req_pc_r, req_pc_s;
  logic [PC_MAX_B:2] redir_pc_r, redir_pc_s;
  logic [31:2]       buf_inst_r;
  logic [PC_MAX_B:2] buf_pc_r;
  logic              buf_we_s;
  logic              deliver_s;
  logic [31:2]       deliver_inst_s;
  logic [PC_MAX_B:2] deliver_pc_s;
  logic              accept_s;

  // Outputs come from registered state only, so the memory never sees a
  // combinational path from ack/stall/redirect back to req/addr.
  assign imem.req  = (state_r != HOLD);
  assign imem.addr = req_pc_r;
  assign accept_s  = !stall_decode && !flush_decode;

  // Next-state, next-address and delivery selection.
  always_comb begin
    state_s        = state_r;
    req_pc_s       = req_pc_r;
    redir_pc_s     = redir_pc_r;
    buf_we_s       = 1'b0;
    deliver_s      = 1'b0;
    deliver_inst_s = NOP;
    deliver_pc_s   = req_pc_r;
    case (state_r)
      FETCH: begin
        if (imem.ack) begin
          if (pcCTWriteEnable) begin
            req_pc_s = controlTransferNewPC;
          end else begin
            req_pc_s = req_pc_r + PC_ONE;
            if (accept_s) begin
              deliver_s      = 1'b1;
              deliver_inst_s = imem.data;
              deliver_pc_s   = req_pc_r;
            end else begin
              // Flush/stall must not lose the word; park it.
              buf_we_s = 1'b1;
              state_s  = HOLD;
            end
          end
        end else if (pcCTWriteEnable) begin
          // Address must stay put until the memory acks it.
          redir_pc_s = controlTransferNewPC;
          state_s    = DISCARD;
        end else begin
          state_s = FETCH;
        end
      end
      HOLD: begin
        if (pcCTWriteEnable) begin
          req_pc_s = controlTransferNewPC;
          state_s  = FETCH;
        end else if (accept_s) begin
          deliver_s      = 1'b1;
          deliver_inst_s = buf_inst_r;
          deliver_pc_s   = buf_pc_r;
          state_s        = FETCH;
        end else begin
          state_s = HOLD;
        end
      end
      DISCARD: begin
        if (pcCTWriteEnable) begin
          redir_pc_s = controlTransferNewPC;
        end else begin
          redir_pc_s = redir_pc_r;
        end
        if (imem.ack) begin
          req_pc_s = pcCTWriteEnable ? controlTransferNewPC : redir_pc_r;
          state_s  = FETCH;
        end else begin
          state_s = DISCARD;
        end
      end
      default: begin
        state_s = FETCH;
      end
    endcase
  end

  // State and address registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= FETCH;
      req_pc_r   <= RESET_PC;
      redir_pc_r <= RESET_PC;
    end else begin
      state_r    <= state_s;
      req_pc_r   <= req_pc_s;
      redir_pc_r <= redir_pc_s;
    end
  end

  // One-entry buffer for a word fetched while decode could not take it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buf_inst_r <= NOP;
      buf_pc_r   <= RESET_PC;
    end else if (buf_we_s) begin
      buf_inst_r <= imem.data;
      buf_pc_r   <= req_pc_r;
    end else begin
      buf_inst_r <= buf_inst_r;
      buf_pc_r   <= buf_pc_r;
    end
  end

  // Fetch->decode register: flush > stall > delivered word > nop.
  // A nop keeps the previous PC.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instruction_decode <= NOP;
      currentPC_decode   <= RESET_PC;
    end else if (flush_decode) begin
      instruction_decode <= NOP;
    end else if (stall_decode) begin
      instruction_decode <= instruction_decode;
    end else if (deliver_s) begin
      instruction_decode <= deliver_inst_s;
      currentPC_decode   <= deliver_pc_s;
    end else begin
      instruction_decode <= NOP;
    end
  end

`ifdef JZJPCC_FETCH_PERF_COUNTERS_EN
  logic fetched_inc_s;
  logic bubble_inc_s;

  // A bubble is a nop entering decode while decode is not stalled.
  assign fetched_inc_s = deliver_s && accept_s;
  assign bubble_inc_s  = !stall_decode && (flush_decode || !deliver_s);

  // Performance counters, wrapping modulo 2^32.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetchedCount_fetch <= 32'd0;
      bubbleCount_fetch  <= 32'd0;
    end else begin
      fetchedCount_fetch <= fetchedCount_fetch + (fetched_inc_s ? 32'd1 : 32'd0);
      bubbleCount_fetch  <= bubbleCount_fetch + (bubble_inc_s ? 32'd1 : 32'd0);
    end
  end
`endif

endmodule
